// File: rtl/regfile_pkg.sv
// Shared helpers for the register file core and its bench: address width,
// the hard-wired zero register index and flat-port slice offsets.
package regfile_pkg;

    localparam int ZERO_ADDR = 0;

    // Address width for a given depth, never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Low bit of lane k in a flat bus of w-bit lanes.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_nrmw_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, write ports,
// scoreboard allocation and the full busy vector.
interface regfile_nrmw_sb_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    import regfile_pkg::*;

    localparam int AW = addr_w(DEPTH);

    logic [NUM_RD*AW-1:0]    i_rd_addr;
    logic [NUM_RD*WIDTH-1:0] o_rd_data;
    logic [NUM_RD-1:0]       o_rd_busy;
    logic [NUM_WR-1:0]       i_wr_en;
    logic [NUM_WR*AW-1:0]    i_wr_addr;
    logic [NUM_WR*WIDTH-1:0] i_wr_data;
    logic                    i_alloc_en;
    logic [AW-1:0]           i_alloc_addr;
    logic [DEPTH-1:0]        o_busy_vec;

    modport master (
        output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_alloc_en, i_alloc_addr,
        input  o_rd_data, o_rd_busy, o_busy_vec
    );

    modport slave (
        input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_alloc_en, i_alloc_addr,
        output o_rd_data, o_rd_busy, o_busy_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags: set on allocation, cleared on writeback, set wins
// when both hit the same register in one cycle.
module regfile_scoreboard #(
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] set_vec,
    input  logic [DEPTH-1:0] clr_vec,
    output logic [DEPTH-1:0] busy_vec
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_vec <= '0;
        else        busy_vec <= set_vec | (busy_vec & ~clr_vec);
    end

endmodule

// File: rtl/regfile_nrmw_sb.sv
// Multi-port register file with busy scoreboard for the decode stage.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to read ports.
import regfile_pkg::*;

module regfile_nrmw_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_nrmw_sb_if.slave bus
);

    localparam int AW = addr_w(DEPTH);

    logic [NUM_RD-1:0][AW-1:0]    rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic [NUM_WR-1:0][AW-1:0]    wr_addr;
    logic [NUM_WR-1:0][WIDTH-1:0] wr_data;
    logic [DEPTH-1:0][WIDTH-1:0]  regs, regs_nxt;
    logic [DEPTH-1:0]             wr_hit, alloc_hit, busy_vec;

    function automatic logic writable(input int r);
        return !(ZERO_REG != 0 && r == ZERO_ADDR);
    endfunction

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
        assign rd_addr[k] = bus.i_rd_addr[slice_lo(k, AW) +: AW];
    end

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_unpack
        assign wr_addr[p] = bus.i_wr_addr[slice_lo(p, AW) +: AW];
        assign wr_data[p] = bus.i_wr_data[slice_lo(p, WIDTH) +: WIDTH];
    end

    // Decoding by register index keeps out-of-range addresses from ever
    // matching; ascending port order lets the highest-index port win.
    always_comb begin
        regs_nxt  = regs;
        wr_hit    = '0;
        alloc_hit = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (writable(r)) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (bus.i_wr_en[p] && wr_addr[p] == AW'(r)) begin
                        regs_nxt[r] = wr_data[p];
                        wr_hit[r]   = 1'b1;
                    end
                end
                alloc_hit[r] = bus.i_alloc_en && bus.i_alloc_addr == AW'(r);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs <= '0;
        else        regs <= regs_nxt;
    end

    regfile_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_vec  (alloc_hit),
        .clr_vec  (wr_hit),
        .busy_vec (busy_vec)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
        logic hit;
`endif
        always_comb begin
            rd_data[k] = '0;
            rd_busy[k] = 1'b0;
`ifdef REGFILE_BYPASS_EN
            hit = 1'b0;
`endif
            for (int r = 0; r < DEPTH; r++) begin
                if (writable(r) && rd_addr[k] == AW'(r)) begin
                    rd_data[k] = regs[r];
                    rd_busy[k] = busy_vec[r];
`ifdef REGFILE_BYPASS_EN
                    hit = 1'b1;
`endif
                end
            end
`ifdef REGFILE_BYPASS_EN
            // hit already implies an in-range, non-zero address.
            for (int p = 0; p < NUM_WR; p++) begin
                if (hit && bus.i_wr_en[p] && wr_addr[p] == rd_addr[k]) begin
                    rd_data[k] = wr_data[p];
                    rd_busy[k] = bus.i_alloc_en && bus.i_alloc_addr == rd_addr[k];
                end
            end
`endif
        end
    end

    assign bus.o_rd_data  = rd_data;
    assign bus.o_rd_busy  = rd_busy;
    assign bus.o_busy_vec = busy_vec;

endmodule
